uart_tx_arbiter: RTL and testbench

Shares one uart_tx byte transmitter between NUM_REQ requesters (debug command responder, capture dump engine, status reporter, etc.). Arbitrates round-robin at message granularity: a granted requester keeps the transmitter until it sends a byte flagged last, so messages never interleave on the serial line. Sits in top between the requesters and the uart_tx instance; the downstream tx_req/tx_data/tx_ready pins connect directly to uart_tx.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the uart_tx message arbiter
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request after ptr_i, wrapping at N
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int j;

    // Scan from the farthest offset down so the nearest requester after ptr_i wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = N; k >= 1; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                idx_o = W'(j);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one uart_tx; UART_ARB_TIMEOUT_EN adds stalled-owner release
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int GW             = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_req,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [GW-1:0]             grant_id,
    output logic                      busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    arb_state_e    state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_ptr_q;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          xfer;

    rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Byte path is a pure mux while locked so each byte costs no extra cycle.
    always_comb begin
        tx_req    = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_q == LOCKED) begin
            tx_req             = req_valid[grant_q];
            tx_data            = req_data[grant_q*BYTE_W +: BYTE_W];
            req_ready[grant_q] = tx_ready;
        end
    end

    assign xfer     = (state_q == LOCKED) && req_valid[grant_q] && tx_ready;
    assign grant_id = grant_q;
    assign busy     = (state_q == LOCKED);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] idle_cnt_q;
    logic          timeout_q;

    assign timeout = timeout_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= GW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q    <= pick_idx;
                        state_q    <= LOCKED;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (xfer && req_last[grant_q]) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_q;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (xfer) begin
                        idle_cnt_q <= '0;
                    end else if (!req_valid[grant_q]) begin
                        // Owner went quiet too long: hand the line to the next requester.
                        if (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                            state_q   <= IDLE;
                            rr_ptr_q  <= grant_q;
                            timeout_q <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data  = '0;
    logic [N-1:0]     req_last  = '0;
    logic [N-1:0]     req_ready;
    logic             tx_req;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [1:0]       grant_id;
    logic             busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic             timeout;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tmo_cnt  = 0;
    int tmo_edge = 0;

    logic [8:0] srcq [N][$];
    logic [9:0] sb[$];
    int         xfer_edges[$];
    logic [N-1:0] fired;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

`ifdef UART_ARB_TIMEOUT_EN
    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
`else
    uart_tx_arbiter #(.NUM_REQ(N)) dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester models: each presents the head of its byte queue, retiring it on handshake.
    always begin
        @(negedge clk);
        fired = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
            end
            if (srcq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = srcq[i][0][7:0];
                req_last[i]        = srcq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Downstream monitor: every accepted byte must match the next scoreboard entry.
    always @(negedge clk) begin
        logic [9:0] e;
        if (reset && tx_req && tx_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_byte", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                xfer_edges.push_back(cyc + 1);
                check("tx_data", tx_data, e[7:0]);
                check("grant_id", grant_id, e[9:8]);
                check("req_ready_onehot", req_ready, 32'd1 << e[9:8]);
            end
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (timeout) begin
            tmo_cnt++;
            tmo_edge = cyc;
        end
`endif
    end

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        sb.delete();
        xfer_edges.delete();
        tmo_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!(busy && tx_req) && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(tag, {30'd0, busy, tx_req}, 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        reset = 1'b1;
        @(posedge clk);
        #2;

        // 1: single requester, two-byte message
        srcq[0].push_back({1'b0, 8'h48});
        srcq[0].push_back({1'b1, 8'h65});
        sb.push_back({2'd0, 8'h48});
        sb.push_back({2'd0, 8'h65});
        @(posedge clk);
        #2;
        check("t1_arb_latency_tx_req", tx_req, 0);
        check("t1_arb_latency_busy", busy, 0);
        @(posedge clk);
        #2;
        check("t1_locked_busy", busy, 1);
        check("t1_first_data", tx_data, 8'h48);
        wait_done("t1_done");
        check("t1_busy_drop", busy, 0);
        check("t1_grant", grant_id, 0);

        // 2: two simultaneous three-byte messages, no interleave
        do_reset();
        srcq[0].push_back({1'b0, 8'h01});
        srcq[0].push_back({1'b0, 8'h02});
        srcq[0].push_back({1'b1, 8'h03});
        srcq[2].push_back({1'b0, 8'h21});
        srcq[2].push_back({1'b0, 8'h22});
        srcq[2].push_back({1'b1, 8'h23});
        sb.push_back({2'd0, 8'h01});
        sb.push_back({2'd0, 8'h02});
        sb.push_back({2'd0, 8'h03});
        sb.push_back({2'd2, 8'h21});
        sb.push_back({2'd2, 8'h22});
        sb.push_back({2'd2, 8'h23});
        wait_done("t2_done");
        check("t2_grant_final", grant_id, 2);

        // 3: all requesters streaming one-byte messages rotate 0,1,2,3
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                srcq[i].push_back({1'b1, 8'(8'h30 + 8'(16 * r) + 8'(i))});
                sb.push_back({2'(i), 8'(8'h30 + 8'(16 * r) + 8'(i))});
            end
        end
        wait_done("t3_done");

        // 4: downstream stall mid-byte
        do_reset();
        tx_ready = 1'b0;
        srcq[1].push_back({1'b0, 8'hA5});
        srcq[1].push_back({1'b1, 8'h5A});
        sb.push_back({2'd1, 8'hA5});
        sb.push_back({2'd1, 8'h5A});
        wait_busy("t4_locked");
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #2;
            check("t4_stall_tx_req", tx_req, 1);
            check("t4_stall_tx_data", tx_data, 8'hA5);
            check("t4_stall_req_ready", req_ready, 0);
        end
        tx_ready = 1'b1;
        #1;
        check("t4_ready_passthru", req_ready, 4'b0010);
        wait_done("t4_done");

        // 5: async reset while requester 1 owns the line
        do_reset();
        tx_ready = 1'b0;
        srcq[1].push_back({1'b0, 8'hB1});
        srcq[1].push_back({1'b0, 8'hB2});
        srcq[1].push_back({1'b1, 8'hB3});
        wait_busy("t5_locked");
        check("t5_grant_before", grant_id, 1);
        #3;
        reset = 1'b0;
        #1;
        check("t5_async_tx_req", tx_req, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_req_ready", req_ready, 0);
        check("t5_async_grant", grant_id, 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        repeat (2) @(posedge clk);
        #2;
        reset    = 1'b1;
        tx_ready = 1'b1;
        srcq[0].push_back({1'b1, 8'h70});
        srcq[1].push_back({1'b1, 8'h71});
        sb.push_back({2'd0, 8'h70});
        sb.push_back({2'd1, 8'h71});
        wait_done("t5_done");

`ifdef UART_ARB_TIMEOUT_EN
        // 6: owner goes silent after one byte, timeout hands off to requester 3
        do_reset();
        srcq[0].push_back({1'b0, 8'h11});
        srcq[3].push_back({1'b1, 8'h33});
        sb.push_back({2'd0, 8'h11});
        sb.push_back({2'd3, 8'h33});
        wait_done("t6_done");
        check("t6_timeout_pulses", tmo_cnt, 1);
        check("t6_timeout_delay", tmo_edge - xfer_edges[0], 16);
        check("t6_grant_after", grant_id, 3);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
